// File: rtl/instr_pack.sv
// ============================================================================
// instr_pack: packs decoded instruction fields into 32-bit words, buffers them
// in a FIFO and drains them to the instruction-memory write port.  Rev 1.0
// ============================================================================
`default_nettype none

module instr_pack #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [1:0]    i_fmt,
  input  logic [5:0]    i_code,
  input  logic [4:0]    i_ri,
  input  logic [4:0]    i_rj,
  input  logic [4:0]    i_rk,
  input  logic [10:0]   i_func,
  input  logic [15:0]   i_imme_2,
  input  logic [25:0]   i_imme_0,
  input  logic          i_last,
  input  logic          i_stall,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_wdata,
  output logic          o_done,
  output logic          o_err,
  output logic [AW:0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [AW-1:0] addr_ptr;
  logic          last_seen;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          init;
  logic [31:0]   packed_word;

  // Extra pointer bit distinguishes full from empty when indices coincide.
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign o_ready = (state == LOAD) && !full && !last_seen;
  assign accept = i_valid && o_ready;
  assign push   = accept && (i_fmt != 2'b11);
  assign pop    = (state == LOAD) && !empty && !i_stall;
  assign init   = i_start && (state != LOAD);
  assign o_done = (state == DONE);

  always_comb begin
    packed_word = 32'd0;
    case (i_fmt)
      2'b00:   packed_word = {i_code, i_ri, i_rj, i_rk, i_func};
      2'b01:   packed_word = {i_code, i_ri, i_rj, i_imme_2};
      2'b10:   packed_word = {i_code, i_imme_0};
      default: packed_word = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = LOAD;
      // Once last_seen is set nothing more is accepted, so an empty FIFO
      // also means no pop is happening this cycle.
      LOAD:    if (last_seen && empty) state_nx = DONE;
      DONE:    if (i_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= packed_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      addr_ptr  <= '0;
      last_seen <= 1'b0;
      o_we      <= 1'b0;
      o_addr    <= '0;
      o_wdata   <= '0;
      o_count   <= '0;
      o_err     <= 1'b0;
    end else begin
      o_we <= 1'b0;
      if (init) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        addr_ptr  <= i_base;
        last_seen <= 1'b0;
        o_count   <= '0;
        o_err     <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr   <= rd_ptr + PTR_ONE;
          o_we     <= 1'b1;
          o_wdata  <= mem[rd_ptr[PW-1:0]];
          o_addr   <= addr_ptr;
          addr_ptr <= addr_ptr + ADDR_ONE;
          o_count  <= o_count + CNT_ONE;
        end
        if (accept && i_last) begin
          last_seen <= 1'b1;
        end
        if (accept && (i_fmt == 2'b11)) begin
          o_err <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_pack.sv
// Scoreboard bench for instr_pack: stimulus pushes expected writes, a monitor
// pops and compares them whenever o_we is seen.
`default_nettype none

module tb_instr_pack;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, valid, last, stall;
  logic [AW-1:0] base;
  logic [1:0]    fmt;
  logic [5:0]    code;
  logic [4:0]    ri, rj, rk;
  logic [10:0]   func;
  logic [15:0]   imme_2;
  logic [25:0]   imme_0;
  logic          ready, we, done, err;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [AW:0]   count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int we_gap = 0;
  logic [AW-1:0] exp_addr;
  logic [31:0]   q_data[$];
  logic [AW-1:0] q_addr[$];

  instr_pack #(.DEPTH(4), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base),
    .i_valid(valid), .o_ready(ready), .i_fmt(fmt), .i_code(code),
    .i_ri(ri), .i_rj(rj), .i_rk(rk), .i_func(func),
    .i_imme_2(imme_2), .i_imme_0(imme_0), .i_last(last), .i_stall(stall),
    .o_we(we), .o_addr(addr), .o_wdata(wdata), .o_done(done),
    .o_err(err), .o_count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (we) begin
      tests++;
      if (q_data.size() == 0) begin
        fails++;
        $display("FAIL unexpected_we: addr=%h data=%h, required no write", addr, wdata);
      end else begin
        logic [31:0]   ed;
        logic [AW-1:0] ea;
        ed = q_data.pop_front();
        ea = q_addr.pop_front();
        if (wdata !== ed || addr !== ea) begin
          fails++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", addr, wdata, ea, ed);
        end
      end
      we_gap = cyc - last_we_cyc;
      last_we_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic begin_session(input logic [AW-1:0] b);
    base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = b;
  endtask

  // Offer one field set; expected word is queued when it will be accepted.
  task automatic send(input logic [1:0] f, input logic [5:0] c, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] k, input logic [10:0] fn,
                      input logic [15:0] i2, input logic [25:0] i0, input logic l,
                      input logic [31:0] exp, input logic exp_write);
    int n = 0;
    fmt = f; code = c; ri = a; rj = b; rk = k; func = fn;
    imme_2 = i2; imme_0 = i0; last = l; valid = 1'b1;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: ready=0 after %0d cycles, required 1", n);
    end else if (exp_write) begin
      q_data.push_back(exp);
      q_addr.push_back(exp_addr);
      exp_addr = exp_addr + 1'b1;
    end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_sb_empty"}, q_data.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; valid = 1'b1; last = 1'b0; stall = 1'b0;
    base = '0; fmt = '0; code = '0; ri = '0; rj = '0; rk = '0;
    func = '0; imme_2 = '0; imme_0 = '0; exp_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_we",    32'(we),    32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b0; start = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'd0);

    // R-type single word
    begin_session(8'h10);
    send(2'b00, 6'b001100, 5'b11001, 5'b10011, 5'b00110, 11'b01100110011,
         16'h0, 26'h0, 1'b1, 32'h33333333, 1'b1);
    wait_done("rtype");
    check("rtype_count", 32'(count), 32'd1);
    check("rtype_addr_hold", 32'(addr), 32'h10);

    // I then J back to back, writes on consecutive cycles
    begin_session(8'h20);
    send(2'b01, 6'b001010, 5'b11011, 5'b10011, 5'h0, 11'h0,
         16'hB123, 26'h0, 1'b0, 32'h2B73B123, 1'b1);
    send(2'b10, 6'b001011, 5'h0, 5'h0, 5'h0, 11'h0,
         16'h0, 26'h373F13B, 1'b1, 32'h2F73F13B, 1'b1);
    wait_done("ij");
    check("ij_count", 32'(count), 32'd2);
    check("ij_gap", 32'(we_gap), 32'd1);

    // Backpressure: FIFO fills at 4 under stall
    begin_session(8'h30);
    stall = 1'b1;
    for (int i = 1; i <= 4; i++)
      send(2'b00, 6'(i), 5'h0, 5'h0, 5'h0, 11'(i), 16'h0, 26'h0, 1'b0,
           {6'(i), 15'h0, 11'(i)}, 1'b1);
    check("bp_full_ready", 32'(ready), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_held_count", 32'(count), 32'd0);
    stall = 1'b0;
    send(2'b00, 6'd5, 5'h0, 5'h0, 5'h0, 11'd5, 16'h0, 26'h0, 1'b1,
         32'h14000005, 1'b1);
    wait_done("bp");
    check("bp_count", 32'(count), 32'd5);

    // Address wrap, then an illegal last set
    begin_session(8'hFF);
    send(2'b10, 6'h3F, 5'h0, 5'h0, 5'h0, 11'h0, 16'h0, 26'h0, 1'b0,
         32'hFC000000, 1'b1);
    send(2'b10, 6'h00, 5'h0, 5'h0, 5'h0, 11'h0, 16'h0, 26'h3FFFFFF, 1'b0,
         32'h03FFFFFF, 1'b1);
    send(2'b11, 6'h15, 5'h1, 5'h2, 5'h3, 11'h4, 16'h5, 26'h6, 1'b1,
         32'h0, 1'b0);
    wait_done("wrap");
    check("wrap_err",   32'(err),   32'd1);
    check("wrap_count", 32'(count), 32'd2);
    check("wrap_addr",  32'(addr),  32'h00);

    // Reset mid-session discards queued words
    begin_session(8'h40);
    check("reinit_err", 32'(err), 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++)
      send(2'b00, 6'h2A, 5'h0, 5'h0, 5'h0, 11'h0, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);

    // Start pulse during LOAD is ignored
    begin_session(8'h50);
    stall = 1'b1;
    send(2'b01, 6'h01, 5'h02, 5'h03, 5'h0, 11'h0, 16'hBEEF, 26'h0, 1'b0,
         32'h0443BEEF, 1'b1);
    base = 8'h90; start = 1'b1;
    @(negedge clk);
    start = 1'b0; stall = 1'b0;
    send(2'b10, 6'h02, 5'h0, 5'h0, 5'h0, 11'h0, 16'h0, 26'h0000123, 1'b1,
         32'h08000123, 1'b1);
    wait_done("ign_start");
    check("ign_start_count", 32'(count), 32'd2);
    check("ign_start_addr",  32'(addr),  32'h51);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
